// File: rtl/prco_alu_mc.sv
// prco execute-stage ALU: single-cycle logic/arith/shift ops plus an optional
// iterative shift-add multiplier, enabled by defining PRCO_ALU_MUL_EN.

// Default opcode encodings; an external ISA header defining these first takes precedence.
`ifndef PRCO_OP_NOP
`define PRCO_OP_NOP  5'h00
`endif
`ifndef PRCO_OP_ADD
`define PRCO_OP_ADD  5'h01
`endif
`ifndef PRCO_OP_SUB
`define PRCO_OP_SUB  5'h02
`endif
`ifndef PRCO_OP_CMP
`define PRCO_OP_CMP  5'h03
`endif
`ifndef PRCO_OP_AND
`define PRCO_OP_AND  5'h04
`endif
`ifndef PRCO_OP_OR
`define PRCO_OP_OR   5'h05
`endif
`ifndef PRCO_OP_XOR
`define PRCO_OP_XOR  5'h06
`endif
`ifndef PRCO_OP_SHL
`define PRCO_OP_SHL  5'h07
`endif
`ifndef PRCO_OP_SHR
`define PRCO_OP_SHR  5'h08
`endif
`ifndef PRCO_OP_ASR
`define PRCO_OP_ASR  5'h09
`endif
`ifndef PRCO_OP_MOV
`define PRCO_OP_MOV  5'h0A
`endif
`ifndef PRCO_OP_MOVI
`define PRCO_OP_MOVI 5'h0B
`endif
`ifndef PRCO_OP_LW
`define PRCO_OP_LW   5'h0C
`endif
`ifndef PRCO_OP_SW
`define PRCO_OP_SW   5'h0D
`endif
`ifndef PRCO_OP_MUL
`define PRCO_OP_MUL  5'h0E
`endif

module prco_alu_mc #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned IMM_W  = 8,
   parameter int unsigned SIMM_W = 5,
   parameter int unsigned OP_W   = 5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_ce,
   input  logic              i_dec_req_ram,
   input  logic [OP_W-1:0]   i_op,
   input  logic [DATA_W-1:0] i_data,
   input  logic [DATA_W-1:0] i_datb,
   input  logic [IMM_W-1:0]  i_imm8,
   input  logic [SIMM_W-1:0] i_simm5,
   output logic [DATA_W-1:0] q_result,
   output logic [3:0]        q_flags,
   output logic              q_ce_reg,
   output logic              q_ce_ram,
   output logic              q_done,
   output logic              q_busy,
   output logic              q_err
);

   localparam int unsigned SH_W  = $clog2(DATA_W);
   localparam int unsigned MSB   = DATA_W - 1;

   localparam logic [OP_W-1:0] OP_NOP  = OP_W'(`PRCO_OP_NOP);
   localparam logic [OP_W-1:0] OP_ADD  = OP_W'(`PRCO_OP_ADD);
   localparam logic [OP_W-1:0] OP_SUB  = OP_W'(`PRCO_OP_SUB);
   localparam logic [OP_W-1:0] OP_CMP  = OP_W'(`PRCO_OP_CMP);
   localparam logic [OP_W-1:0] OP_AND  = OP_W'(`PRCO_OP_AND);
   localparam logic [OP_W-1:0] OP_OR   = OP_W'(`PRCO_OP_OR);
   localparam logic [OP_W-1:0] OP_XOR  = OP_W'(`PRCO_OP_XOR);
   localparam logic [OP_W-1:0] OP_SHL  = OP_W'(`PRCO_OP_SHL);
   localparam logic [OP_W-1:0] OP_SHR  = OP_W'(`PRCO_OP_SHR);
   localparam logic [OP_W-1:0] OP_ASR  = OP_W'(`PRCO_OP_ASR);
   localparam logic [OP_W-1:0] OP_MOV  = OP_W'(`PRCO_OP_MOV);
   localparam logic [OP_W-1:0] OP_MOVI = OP_W'(`PRCO_OP_MOVI);
   localparam logic [OP_W-1:0] OP_LW   = OP_W'(`PRCO_OP_LW);
   localparam logic [OP_W-1:0] OP_SW   = OP_W'(`PRCO_OP_SW);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0] res_nxt;
   logic [3:0]        flags_nxt;
   logic              ce_reg_nxt, ce_ram_nxt, done_nxt, busy_nxt, err_nxt;

   // Single-cycle datapath
   logic [DATA_W:0]   add_w, sub_w;
   logic [SH_W-1:0]   sh_amt;
   logic [DATA_W-1:0] simm_ext, imm_ext;
   logic [DATA_W-1:0] alu_res;
   logic              alu_c, alu_v, alu_wr_res, alu_wr_flags, alu_err, alu_no_wb;
   logic [3:0]        alu_flags;

   assign add_w    = {1'b0, i_data} + {1'b0, i_datb};
   assign sub_w    = {1'b0, i_data} - {1'b0, i_datb};
   assign sh_amt   = i_datb[SH_W-1:0];
   assign simm_ext = {{(DATA_W-SIMM_W){i_simm5[SIMM_W-1]}}, i_simm5};
   assign imm_ext  = {{(DATA_W-IMM_W){1'b0}}, i_imm8};

   always_comb begin
      alu_res      = '0;
      alu_c        = 1'b0;
      alu_v        = 1'b0;
      alu_wr_res   = 1'b1;
      alu_wr_flags = 1'b0;
      alu_err      = 1'b0;
      alu_no_wb    = 1'b0;
      case (i_op)
         OP_LW, OP_SW: alu_res = i_datb + simm_ext;
         OP_MOVI:      alu_res = imm_ext;
         OP_MOV:       alu_res = i_datb;
         OP_ADD: begin
            alu_res      = add_w[MSB:0];
            alu_wr_flags = 1'b1;
            alu_c        = add_w[DATA_W];
            alu_v        = (i_data[MSB] == i_datb[MSB]) && (add_w[MSB] != i_data[MSB]);
         end
         OP_SUB, OP_CMP: begin
            // CMP shares the subtractor but leaves the result register alone
            alu_res      = sub_w[MSB:0];
            alu_wr_flags = 1'b1;
            alu_c        = ~sub_w[DATA_W];
            alu_v        = (i_data[MSB] != i_datb[MSB]) && (sub_w[MSB] != i_data[MSB]);
            alu_wr_res   = (i_op == OP_SUB);
            alu_no_wb    = (i_op == OP_CMP);
         end
         OP_AND: begin
            alu_res      = i_data & i_datb;
            alu_wr_flags = 1'b1;
         end
         OP_OR: begin
            alu_res      = i_data | i_datb;
            alu_wr_flags = 1'b1;
         end
         OP_XOR: begin
            alu_res      = i_data ^ i_datb;
            alu_wr_flags = 1'b1;
         end
         OP_SHL:  alu_res = i_data << sh_amt;
         OP_SHR:  alu_res = i_data >> sh_amt;
         OP_ASR:  alu_res = $signed(i_data) >>> sh_amt;
         OP_NOP:  alu_no_wb = 1'b1;
         default: alu_err = 1'b1;
      endcase
   end

   assign alu_flags = {alu_res[MSB], (alu_res == '0), alu_c, alu_v};

`ifdef PRCO_ALU_MUL_EN
   localparam int unsigned     CNT_W  = SH_W + 1;
   localparam logic [OP_W-1:0] OP_MUL = OP_W'(`PRCO_OP_MUL);

   // Shift-add multiplier state; one partial product is folded in per cycle
   logic [DATA_W-1:0] acc, acc_nxt, acc_step;
   logic [DATA_W-1:0] mcand, mcand_nxt;
   logic [DATA_W-1:0] mplier, mplier_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              mul_ram, mul_ram_nxt;

   assign acc_step = mplier[0] ? (acc + mcand) : acc;
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_nxt  = state;
      res_nxt    = q_result;
      flags_nxt  = q_flags;
      ce_reg_nxt = 1'b0;
      ce_ram_nxt = 1'b0;
      done_nxt   = 1'b0;
      err_nxt    = 1'b0;
      busy_nxt   = q_busy;
`ifdef PRCO_ALU_MUL_EN
      acc_nxt     = acc;
      mcand_nxt   = mcand;
      mplier_nxt  = mplier;
      cnt_nxt     = cnt;
      mul_ram_nxt = mul_ram;
`endif
      case (state)
         S_IDLE: begin
            if (i_ce) begin
`ifdef PRCO_ALU_MUL_EN
               if (i_op == OP_MUL) begin
                  state_nxt   = S_MUL;
                  busy_nxt    = 1'b1;
                  acc_nxt     = '0;
                  mcand_nxt   = i_data;
                  mplier_nxt  = i_datb;
                  cnt_nxt     = '0;
                  mul_ram_nxt = i_dec_req_ram;
               end else begin
`else
               begin
`endif
                  if (alu_wr_res)   res_nxt   = alu_res;
                  if (alu_wr_flags) flags_nxt = alu_flags;
                  done_nxt = 1'b1;
                  err_nxt  = alu_err;
                  if (!alu_no_wb) begin
                     ce_ram_nxt = i_dec_req_ram;
                     ce_reg_nxt = !i_dec_req_ram;
                  end
               end
            end
         end
`ifdef PRCO_ALU_MUL_EN
         S_MUL: begin
            acc_nxt    = acc_step;
            mcand_nxt  = mcand << 1;
            mplier_nxt = mplier >> 1;
            cnt_nxt    = cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) begin
               state_nxt  = S_IDLE;
               busy_nxt   = 1'b0;
               res_nxt    = acc_step;
               done_nxt   = 1'b1;
               ce_ram_nxt = mul_ram;
               ce_reg_nxt = !mul_ram;
            end
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= S_IDLE;
         q_result <= '0;
         q_flags  <= '0;
         q_ce_reg <= 1'b0;
         q_ce_ram <= 1'b0;
         q_done   <= 1'b0;
         q_busy   <= 1'b0;
         q_err    <= 1'b0;
`ifdef PRCO_ALU_MUL_EN
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         cnt      <= '0;
         mul_ram  <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         q_result <= res_nxt;
         q_flags  <= flags_nxt;
         q_ce_reg <= ce_reg_nxt;
         q_ce_ram <= ce_ram_nxt;
         q_done   <= done_nxt;
         q_busy   <= busy_nxt;
         q_err    <= err_nxt;
`ifdef PRCO_ALU_MUL_EN
         acc      <= acc_nxt;
         mcand    <= mcand_nxt;
         mplier   <= mplier_nxt;
         cnt      <= cnt_nxt;
         mul_ram  <= mul_ram_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_prco_alu_mc.sv
// Directed self-checking bench for prco_alu_mc; the MUL section follows PRCO_ALU_MUL_EN.
module tb_prco_alu_mc;

   localparam logic [4:0] OP_NOP  = 5'h00;
   localparam logic [4:0] OP_ADD  = 5'h01;
   localparam logic [4:0] OP_SUB  = 5'h02;
   localparam logic [4:0] OP_CMP  = 5'h03;
   localparam logic [4:0] OP_AND  = 5'h04;
   localparam logic [4:0] OP_OR   = 5'h05;
   localparam logic [4:0] OP_XOR  = 5'h06;
   localparam logic [4:0] OP_SHL  = 5'h07;
   localparam logic [4:0] OP_SHR  = 5'h08;
   localparam logic [4:0] OP_ASR  = 5'h09;
   localparam logic [4:0] OP_MOV  = 5'h0A;
   localparam logic [4:0] OP_MOVI = 5'h0B;
   localparam logic [4:0] OP_SW   = 5'h0D;
   localparam logic [4:0] OP_MUL  = 5'h0E;
   localparam logic [4:0] OP_BAD  = 5'h1F;

   logic        i_clk = 1'b0;
   logic        i_rst, i_ce, i_dec_req_ram;
   logic [4:0]  i_op;
   logic [15:0] i_data, i_datb;
   logic [7:0]  i_imm8;
   logic [4:0]  i_simm5;
   logic [15:0] q_result;
   logic [3:0]  q_flags;
   logic        q_ce_reg, q_ce_ram, q_done, q_busy, q_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 i_clk = ~i_clk;

   prco_alu_mc dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_dec_req_ram(i_dec_req_ram),
      .i_op(i_op), .i_data(i_data), .i_datb(i_datb), .i_imm8(i_imm8), .i_simm5(i_simm5),
      .q_result(q_result), .q_flags(q_flags), .q_ce_reg(q_ce_reg), .q_ce_ram(q_ce_ram),
      .q_done(q_done), .q_busy(q_busy), .q_err(q_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one op for a single edge, then sample 1 ns after that edge
   task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic ram, input logic [7:0] imm, input logic [4:0] simm);
      i_op = op; i_data = a; i_datb = b; i_dec_req_ram = ram;
      i_imm8 = imm; i_simm5 = simm; i_ce = 1'b1;
      @(posedge i_clk); #1;
      i_ce = 1'b0;
   endtask

   task automatic idle();
      @(posedge i_clk); #1;
   endtask

   task automatic check_pulses(input string tag, input logic reg_e, input logic ram_e,
                               input logic done_e, input logic err_e);
      check({tag, ".ce_reg"}, 32'(q_ce_reg), 32'(reg_e));
      check({tag, ".ce_ram"}, 32'(q_ce_ram), 32'(ram_e));
      check({tag, ".done"},   32'(q_done),   32'(done_e));
      check({tag, ".err"},    32'(q_err),    32'(err_e));
   endtask

   initial begin
      i_rst = 1'b1; i_ce = 1'b0; i_dec_req_ram = 1'b0; i_op = OP_NOP;
      i_data = '0; i_datb = '0; i_imm8 = '0; i_simm5 = '0;
      repeat (2) @(posedge i_clk);
      #1;
      check("rst.result", 32'(q_result), 32'h0);
      check("rst.flags",  32'(q_flags),  32'h0);
      check("rst.busy",   32'(q_busy),   32'h0);
      check_pulses("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      i_rst = 1'b0;
      idle();

      // ADD overflow into the sign bit
      issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 8'h00, 5'h00);
      check("add.result", 32'(q_result), 32'h8000);
      check("add.flags",  32'(q_flags),  32'h9);
      check_pulses("add", 1'b1, 1'b0, 1'b1, 1'b0);
      idle();
      check_pulses("add.after", 1'b0, 1'b0, 1'b0, 1'b0);

      // SW address with negative offset, routed to RAM
      issue(OP_SW, 16'h0000, 16'h0100, 1'b1, 8'h00, 5'b11110);
      check("sw.result", 32'(q_result), 32'h00FE);
      check("sw.flags",  32'(q_flags),  32'h9);
      check_pulses("sw", 1'b0, 1'b1, 1'b1, 1'b0);

      // CMP then back-to-back SUB
      issue(OP_CMP, 16'h0005, 16'h0005, 1'b0, 8'h00, 5'h00);
      check("cmp.result", 32'(q_result), 32'h00FE);
      check("cmp.flags",  32'(q_flags),  32'h6);
      check_pulses("cmp", 1'b0, 1'b0, 1'b1, 1'b0);
      issue(OP_SUB, 16'h0003, 16'h0005, 1'b0, 8'h00, 5'h00);
      check("sub.result", 32'(q_result), 32'hFFFE);
      check("sub.flags",  32'(q_flags),  32'h8);
      check_pulses("sub", 1'b1, 1'b0, 1'b1, 1'b0);

      // Shifts; flags must hold
      issue(OP_ASR, 16'h8010, 16'h0014, 1'b0, 8'h00, 5'h00);
      check("asr.result", 32'(q_result), 32'hF801);
      check("asr.flags",  32'(q_flags),  32'h8);
      issue(OP_SHR, 16'h8010, 16'h0014, 1'b0, 8'h00, 5'h00);
      check("shr.result", 32'(q_result), 32'h0801);
      issue(OP_SHL, 16'h0001, 16'h000F, 1'b0, 8'h00, 5'h00);
      check("shl.result", 32'(q_result), 32'h8000);
      issue(OP_SHL, 16'h1234, 16'h0010, 1'b0, 8'h00, 5'h00);
      check("shl0.result", 32'(q_result), 32'h1234);

      // ADD carry-out to zero, SUB signed overflow
      issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 8'h00, 5'h00);
      check("addc.result", 32'(q_result), 32'h0000);
      check("addc.flags",  32'(q_flags),  32'h6);
      issue(OP_SUB, 16'h8000, 16'h0001, 1'b0, 8'h00, 5'h00);
      check("subv.result", 32'(q_result), 32'h7FFF);
      check("subv.flags",  32'(q_flags),  32'h3);

      // Logic ops clear C and V
      issue(OP_AND, 16'hF0F0, 16'h0FF0, 1'b0, 8'h00, 5'h00);
      check("and.result", 32'(q_result), 32'h00F0);
      check("and.flags",  32'(q_flags),  32'h0);
      issue(OP_OR, 16'h8000, 16'h0001, 1'b0, 8'h00, 5'h00);
      check("or.result", 32'(q_result), 32'h8001);
      check("or.flags",  32'(q_flags),  32'h8);
      issue(OP_XOR, 16'hAAAA, 16'hAAAA, 1'b0, 8'h00, 5'h00);
      check("xor.result", 32'(q_result), 32'h0000);
      check("xor.flags",  32'(q_flags),  32'h4);

      // Moves, NOP and an unknown opcode
      issue(OP_MOVI, 16'hFFFF, 16'hFFFF, 1'b1, 8'hA5, 5'h00);
      check("movi.result", 32'(q_result), 32'h00A5);
      check("movi.flags",  32'(q_flags),  32'h4);
      check_pulses("movi", 1'b0, 1'b1, 1'b1, 1'b0);
      issue(OP_MOV, 16'h0000, 16'hBEEF, 1'b0, 8'h00, 5'h00);
      check("mov.result", 32'(q_result), 32'hBEEF);
      issue(OP_NOP, 16'h1234, 16'h5678, 1'b0, 8'h00, 5'h00);
      check("nop.result", 32'(q_result), 32'h0000);
      check_pulses("nop", 1'b0, 1'b0, 1'b1, 1'b0);
      issue(OP_MOV, 16'h0000, 16'h1111, 1'b0, 8'h00, 5'h00);
      issue(OP_BAD, 16'h1234, 16'h5678, 1'b0, 8'h00, 5'h00);
      check("bad.result", 32'(q_result), 32'h0000);
      check_pulses("bad", 1'b1, 1'b0, 1'b1, 1'b1);
      idle();
      check_pulses("bad.after", 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef PRCO_ALU_MUL_EN
      begin
         int busy_cnt, edges, dones;
         logic got;
         issue(OP_MUL, 16'hFFFD, 16'h0007, 1'b0, 8'h00, 5'h00);
         check("mul.busy0", 32'(q_busy), 32'h1);
         check("mul.done0", 32'(q_done), 32'h0);
         busy_cnt = 1; edges = 0; dones = 0; got = 1'b0;
         for (int k = 0; k < 40 && !got; k++) begin
            if (k == 4) begin
               i_op = OP_ADD; i_data = 16'h1111; i_datb = 16'h2222; i_ce = 1'b1;
            end
            @(posedge i_clk); #1;
            i_ce = 1'b0;
            edges++;
            if (q_busy) busy_cnt++;
            if (q_done) got = 1'b1;
         end
         check("mul.completed", 32'(got), 32'h1);
         check("mul.edges",     32'(edges), 32'd16);
         check("mul.busy_cyc",  32'(busy_cnt), 32'd16);
         check("mul.result",    32'(q_result), 32'hFFEB);
         check("mul.busy_end",  32'(q_busy), 32'h0);
         check_pulses("mul", 1'b1, 1'b0, 1'b1, 1'b0);

         issue(OP_ADD, 16'h0002, 16'h0003, 1'b0, 8'h00, 5'h00);
         check("postmul.result", 32'(q_result), 32'h0005);
         check_pulses("postmul", 1'b1, 1'b0, 1'b1, 1'b0);

         // Reset mid-MUL aborts with no pulse
         issue(OP_MUL, 16'h0003, 16'h0004, 1'b1, 8'h00, 5'h00);
         repeat (5) idle();
         i_rst = 1'b1;
         idle();
         i_rst = 1'b0;
         check("mulrst.result", 32'(q_result), 32'h0);
         check("mulrst.flags",  32'(q_flags),  32'h0);
         check("mulrst.busy",   32'(q_busy),   32'h0);
         check_pulses("mulrst", 1'b0, 1'b0, 1'b0, 1'b0);
         for (int k = 0; k < 20; k++) begin
            idle();
            if (q_done || q_ce_reg || q_ce_ram || q_busy) dones++;
         end
         check("mulrst.quiet", 32'(dones), 32'h0);
      end
`else
      issue(OP_MUL, 16'hFFFD, 16'h0007, 1'b0, 8'h00, 5'h00);
      check("mul.result", 32'(q_result), 32'h0000);
      check("mul.busy",   32'(q_busy),   32'h0);
      check_pulses("mul", 1'b1, 1'b0, 1'b1, 1'b1);
      idle();
      check("mul.busy_after", 32'(q_busy), 32'h0);
      check_pulses("mul.after", 1'b0, 1'b0, 1'b0, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
